// File: rtl/dsa_sched_pkg.sv
// Shared types and constants for the dsa_check scheduler front-end.
package dsa_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } sched_state_t;

    localparam logic [2:0] CFG_P   = 3'd0;
    localparam logic [2:0] CFG_Q   = 3'd1;
    localparam logic [2:0] CFG_G   = 3'd2;
    localparam logic [2:0] CFG_PP  = 3'd3;
    localparam logic [2:0] CFG_R2P = 3'd4;
    localparam logic [2:0] CFG_QP  = 3'd5;
    localparam logic [2:0] CFG_R2Q = 3'd6;
    localparam int         CFG_NUM = 7;

endpackage

// File: rtl/dsa_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request after 'last'.
module dsa_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);
    localparam int IW = $clog2(N);

    logic          hit;
    logic [IW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest request wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        hit     = 1'b0;
        idx     = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % N);
            if (en && req[idx]) begin
                hit     = 1'b1;
                gnt_idx = idx;
            end
        end
        if (hit) gnt[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/dsa_check_sched.sv
// Config registers, round-robin request scheduling and verdict return for one dsa_check engine.
// Optional range rejection of r/s at accept is enabled by defining DSA_SCHED_RANGE_CHECK_EN.
module dsa_check_sched
    import dsa_sched_pkg::*;
#(
    parameter int LEN     = 64,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [2:0]             cfg_addr,
    input  logic [LEN-1:0]         cfg_wdata,
    output logic                   cfg_busy,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*LEN-1:0]   req_y,
    input  logic [N_REQ*LEN-1:0]   req_r,
    input  logic [N_REQ*LEN-1:0]   req_s,
    input  logic [N_REQ*LEN-1:0]   req_z,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic                   rsp_ok,
    output logic                   rsp_err,
    output logic                   eng_start,
    output logic [LEN-1:0]         eng_p,
    output logic [LEN-1:0]         eng_q,
    output logic [LEN-1:0]         eng_g,
    output logic [LEN-1:0]         eng_p_prime,
    output logic [LEN-1:0]         eng_r2_mod_p,
    output logic [LEN-1:0]         eng_q_prime,
    output logic [LEN-1:0]         eng_r2_mod_q,
    output logic [LEN-1:0]         eng_y,
    output logic [LEN-1:0]         eng_r,
    output logic [LEN-1:0]         eng_s,
    output logic [LEN-1:0]         eng_z,
    input  logic                   eng_valid,
    input  logic                   eng_done
);
    localparam int            IW   = $clog2(N_REQ);
    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);

    sched_state_t   state_q, state_d;
    logic [IW-1:0]  last_q, last_d, owner_q, owner_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ok_q, ok_d, err_q, err_d;
    logic [LEN-1:0] y_q, y_d, r_q, r_d, s_q, s_d, z_q, z_d;
    logic [LEN-1:0] cfg_q [CFG_NUM];
    logic [LEN-1:0] cfg_d [CFG_NUM];

    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_idx;
    logic             grant_en, range_bad;
    logic [LEN-1:0]   sel_y, sel_r, sel_s, sel_z;

    assign grant_en = (state_q == S_IDLE) && !cfg_we && rst_n;

    dsa_rr_arbiter #(.N(N_REQ)) u_arb (
        .req     (req_valid),
        .last    (last_q),
        .en      (grant_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_y = '0;
        sel_r = '0;
        sel_s = '0;
        sel_z = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_y = req_y[i*LEN +: LEN];
                sel_r = req_r[i*LEN +: LEN];
                sel_s = req_s[i*LEN +: LEN];
                sel_z = req_z[i*LEN +: LEN];
            end
        end
    end

`ifdef DSA_SCHED_RANGE_CHECK_EN
    assign range_bad = (sel_r == '0) || (sel_r >= cfg_q[CFG_Q]) ||
                       (sel_s == '0) || (sel_s >= cfg_q[CFG_Q]);
`else
    assign range_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        ok_d    = ok_q;
        err_d   = err_q;
        y_d     = y_q;
        r_d     = r_q;
        s_d     = s_q;
        z_d     = z_q;
        cfg_d   = cfg_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_we) begin
                    for (int i = 0; i < CFG_NUM; i++)
                        if (cfg_addr == 3'(i)) cfg_d[i] = cfg_wdata;
                end else if (|gnt) begin
                    y_d     = sel_y;
                    r_d     = sel_r;
                    s_d     = sel_s;
                    z_d     = sel_z;
                    last_d  = gnt_idx;
                    owner_d = gnt_idx;
                    if (range_bad) begin
                        ok_d    = 1'b0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // cnt_q is still zero on the first WAIT cycle, where done may be stale.
                if (eng_done && cnt_q != '0) begin
                    ok_d    = eng_valid;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    if (cnt_q < TO_C) cnt_d = cnt_q + 1'b1;
                    if (cnt_d >= TO_C) begin
                        ok_d    = 1'b0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= IW'(N_REQ - 1);
            owner_q <= '0;
            cnt_q   <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            y_q     <= '0;
            r_q     <= '0;
            s_q     <= '0;
            z_q     <= '0;
            for (int i = 0; i < CFG_NUM; i++) cfg_q[i] <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            y_q     <= y_d;
            r_q     <= r_d;
            s_q     <= s_d;
            z_q     <= z_d;
            cfg_q   <= cfg_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == S_RESP) rsp_valid[owner_q] = 1'b1;
    end

    assign req_ready    = gnt;
    assign cfg_busy     = (state_q != S_IDLE);
    assign eng_start    = (state_q == S_LAUNCH);
    assign rsp_ok       = ok_q;
    assign rsp_err      = err_q;
    assign eng_p        = cfg_q[CFG_P];
    assign eng_q        = cfg_q[CFG_Q];
    assign eng_g        = cfg_q[CFG_G];
    assign eng_p_prime  = cfg_q[CFG_PP];
    assign eng_r2_mod_p = cfg_q[CFG_R2P];
    assign eng_q_prime  = cfg_q[CFG_QP];
    assign eng_r2_mod_q = cfg_q[CFG_R2Q];
    assign eng_y        = y_q;
    assign eng_r        = r_q;
    assign eng_s        = s_q;
    assign eng_z        = z_q;

endmodule

// File: tb/tb_dsa_check_sched.sv
// Bench for dsa_check_sched: behavioural engine, cycle-level transaction model, directed and random traffic.
module tb_dsa_check_sched;
    localparam int LEN = 64;
    localparam int NR  = 4;
    localparam int TO  = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [LEN-1:0] cfg_wdata = '0;
    logic cfg_busy;
    logic [NR-1:0] req_valid = '0;
    logic [NR-1:0] req_ready;
    logic [NR*LEN-1:0] req_y = '0, req_r = '0, req_s = '0, req_z = '0;
    logic [NR-1:0] rsp_valid;
    logic rsp_ok, rsp_err, eng_start;
    logic [LEN-1:0] eng_p, eng_q, eng_g, eng_p_prime, eng_r2_mod_p, eng_q_prime, eng_r2_mod_q;
    logic [LEN-1:0] eng_y, eng_r, eng_s, eng_z;
    logic eng_valid = 1'b0;
    logic eng_done = 1'b0;

    dsa_check_sched #(.LEN(LEN), .N_REQ(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_busy(cfg_busy), .req_valid(req_valid), .req_ready(req_ready),
        .req_y(req_y), .req_r(req_r), .req_s(req_s), .req_z(req_z),
        .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_err(rsp_err), .eng_start(eng_start),
        .eng_p(eng_p), .eng_q(eng_q), .eng_g(eng_g), .eng_p_prime(eng_p_prime),
        .eng_r2_mod_p(eng_r2_mod_p), .eng_q_prime(eng_q_prime), .eng_r2_mod_q(eng_r2_mod_q),
        .eng_y(eng_y), .eng_r(eng_r), .eng_s(eng_s), .eng_z(eng_z),
        .eng_valid(eng_valid), .eng_done(eng_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Engine: done visible on WAIT cycle D, result = y[0]; done stays stale until restarted.
    int  eng_d = 10;
    bit  eng_hang = 0;
    int  e_cnt = 0, e_d = 0;
    bit  e_run = 0;
    logic e_v = 1'b0;
    always @(posedge clk) begin
        if (eng_start) begin
            e_run <= 1;
            e_cnt <= 1;
            e_d   <= eng_d;
            e_v   <= eng_y[0];
        end else if (e_run) begin
            e_cnt <= e_cnt + 1;
            if (!eng_hang && e_cnt + 1 >= e_d) begin
                eng_done  <= 1'b1;
                eng_valid <= e_v;
                e_run     <= 0;
            end else begin
                eng_done <= 1'b0;
            end
        end
    end

    // Transaction-level model
    bit             m_busy = 0;
    int             m_last = NR - 1, m_own = 0, m_start = -1, m_resp = -1;
    bit             m_ok = 0, m_err = 0;
    logic [LEN-1:0] m_cfg [8];
    logic [LEN-1:0] m_y = '0, m_r = '0, m_s = '0, m_z = '0;
    logic [NR-1:0]  e_ready, e_rsp;
    int             w, lat;
    bit             rej, tmo;

    int             glog[$];
    logic [NR-1:0]  rlog[$];
    bit             oklog[$];
    int             rsp_cnt = 0, rsp_cyc = 0, start_cnt = 0;
    bit             last_ok = 0, last_err = 0;

    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++)
            if (v[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("ready_in_reset", 64'(req_ready), 64'd0);
            m_busy = 0; m_last = NR - 1; m_start = -1; m_resp = -1;
            m_y = '0; m_r = '0; m_s = '0; m_z = '0;
            for (int a = 0; a < 8; a++) m_cfg[a] = '0;
        end else begin
            e_ready = '0;
            e_rsp   = '0;
            w = (m_busy || cfg_we) ? -1 : rr_pick(req_valid, m_last);
            if (w >= 0) e_ready[w] = 1'b1;
            if (m_busy && cyc == m_resp) e_rsp[m_own] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(e_ready));
            chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
            chk("eng_start", 64'(eng_start), 64'(m_busy && cyc == m_start));
            chk("cfg_busy", 64'(cfg_busy), 64'(m_busy));
            if (|e_rsp) begin
                chk("rsp_ok", 64'(rsp_ok), 64'(m_ok));
                chk("rsp_err", 64'(rsp_err), 64'(m_err));
            end
            chk("eng_p", eng_p, m_cfg[0]);
            chk("eng_q", eng_q, m_cfg[1]);
            chk("eng_g", eng_g, m_cfg[2]);
            chk("eng_p_prime", eng_p_prime, m_cfg[3]);
            chk("eng_r2_mod_p", eng_r2_mod_p, m_cfg[4]);
            chk("eng_q_prime", eng_q_prime, m_cfg[5]);
            chk("eng_r2_mod_q", eng_r2_mod_q, m_cfg[6]);
            chk("eng_y", eng_y, m_y);
            chk("eng_r", eng_r, m_r);
            chk("eng_s", eng_s, m_s);
            chk("eng_z", eng_z, m_z);

            for (int i = 0; i < NR; i++) if (req_ready[i]) glog.push_back(i);
            if (|rsp_valid) begin
                rsp_cnt++;
                rsp_cyc = cyc;
                rlog.push_back(rsp_valid);
                oklog.push_back(rsp_ok);
                last_ok  = rsp_ok;
                last_err = rsp_err;
            end
            if (eng_start) start_cnt++;

            if (m_busy) begin
                if (cyc == m_resp) m_busy = 0;
            end else if (cfg_we) begin
                if (cfg_addr != 3'd7) m_cfg[cfg_addr] = cfg_wdata;
            end else if (w >= 0) begin
                m_y = req_y[w*LEN +: LEN];
                m_r = req_r[w*LEN +: LEN];
                m_s = req_s[w*LEN +: LEN];
                m_z = req_z[w*LEN +: LEN];
                m_last = w; m_own = w; m_busy = 1;
                rej = 0;
`ifdef DSA_SCHED_RANGE_CHECK_EN
                rej = (m_r == 0) || (m_r >= m_cfg[1]) || (m_s == 0) || (m_s >= m_cfg[1]);
`endif
                tmo = !rej && (eng_hang || eng_d > TO);
                if (rej) begin
                    m_start = -1;
                    m_resp  = cyc + 1;
                end else begin
                    lat     = 2 + (tmo ? TO : eng_d);
                    m_start = cyc + 1;
                    m_resp  = cyc + lat;
                end
                m_ok  = !rej && !tmo && m_y[0];
                m_err = rej || tmo;
            end
        end
    end

    task automatic cfg_wr(input logic [2:0] a, input logic [LEN-1:0] d);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [LEN-1:0] y, r, s, z);
        req_y[i*LEN +: LEN] = y;
        req_r[i*LEN +: LEN] = r;
        req_s[i*LEN +: LEN] = s;
        req_z[i*LEN +: LEN] = z;
    endtask

    task automatic issue(input int i, input logic [LEN-1:0] y, r, s, z, output int acc_c);
        int t = 0;
        @(posedge clk); #1;
        set_req(i, y, r, s, z);
        req_valid[i] = 1'b1;
        acc_c = -1;
        while (acc_c < 0 && t < 200) begin
            @(negedge clk);
            if (req_ready[i]) acc_c = cyc;
            t++;
        end
        chk("accept_in_time", 64'(acc_c >= 0), 64'd1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int n0);
        int t = 0;
        while (rsp_cnt <= n0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("rsp_in_time", 64'(rsp_cnt > n0), 64'd1);
    endtask

    int acc, r0, s0, g0;
    int exp_g[5];
    logic [NR-1:0] exp_o[5];
    bit exp_ok[5];
    logic [LEN-1:0] ry, rr_, rs;
    int a_rnd;

    initial begin
        for (int a = 0; a < 8; a++) m_cfg[a] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cfg_busy", 64'(cfg_busy), 64'd0);
        chk("rst_eng_q", eng_q, 64'd0);
        chk("rst_eng_y", eng_y, 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_eng_start", 64'(eng_start), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        cfg_wr(3'd0, 64'd7879);
        cfg_wr(3'd1, 64'd101);
        cfg_wr(3'd2, 64'd170);
        cfg_wr(3'd3, 64'h256e1d0c1e8abd09);
        cfg_wr(3'd4, 64'hd48);
        cfg_wr(3'd5, 64'hc5b3f5dc83cd4e93);
        cfg_wr(3'd6, 64'h50);
        cfg_wr(3'd7, 64'hdead);

        // Single verify, D=10
        eng_d = 10;
        r0 = rsp_cnt; s0 = start_cnt;
        issue(0, 64'd4567, 64'd94, 64'd57, 64'd42, acc);
        wait_rsp(r0);
        chk("t1_latency", 64'(rsp_cyc - acc), 64'd12);
        chk("t1_owner", 64'(rlog[rlog.size()-1]), 64'b0001);
        chk("t1_ok", 64'(last_ok), 64'd1);
        chk("t1_starts", 64'(start_cnt - s0), 64'd1);
        chk("t1_eng_p", eng_p, 64'd7879);
        chk("t1_eng_q_prime", eng_q_prime, 64'hc5b3f5dc83cd4e93);
        chk("t1_eng_y", eng_y, 64'd4567);
        chk("t1_eng_z", eng_z, 64'd42);

        // Round-robin with all requesters held valid, D=3
        eng_d = 3;
        r0 = rsp_cnt;
        issue(3, 64'd8, 64'd94, 64'd57, 64'd42, acc);
        wait_rsp(r0);
        g0 = glog.size(); r0 = rsp_cnt;
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) set_req(i, (i % 2 == 0) ? 64'd4567 : 64'd4568, 64'd94, 64'd57, 64'd42);
        req_valid = '1;
        for (int t = 0; t < 300 && glog.size() < g0 + 5; t++) @(negedge clk);
        @(posedge clk); #1;
        req_valid = '0;
        for (int t = 0; t < 300 && rsp_cnt < r0 + 5; t++) @(negedge clk);
        chk("t2_rsp_count", 64'(rsp_cnt - r0), 64'd5);
        exp_g  = '{0, 1, 2, 3, 0};
        exp_o  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_ok = '{1, 0, 1, 0, 1};
        for (int k = 0; k < 5; k++) begin
            if (g0 + k < glog.size()) chk("t2_grant", 64'(glog[g0+k]), 64'(exp_g[k]));
            if (r0 + k < rlog.size()) begin
                chk("t2_owner", 64'(rlog[r0+k]), 64'(exp_o[k]));
                chk("t2_ok", 64'(oklog[r0+k]), 64'(exp_ok[k]));
            end
        end

        // Config write attempted during WAIT
        eng_d = 10;
        r0 = rsp_cnt;
        issue(1, 64'd11, 64'd94, 64'd57, 64'd42, acc);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 64'd7;
        @(negedge clk);
        chk("t3_busy", 64'(cfg_busy), 64'd1);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        wait_rsp(r0);
        chk("t3_q_held", eng_q, 64'd101);

        // Timeout: engine never completes
        eng_hang = 1;
        r0 = rsp_cnt;
        issue(2, 64'd13, 64'd94, 64'd57, 64'd42, acc);
        wait_rsp(r0);
        chk("t4_latency", 64'(rsp_cyc - acc), 64'd66);
        chk("t4_err", 64'(last_err), 64'd1);
        chk("t4_ok", 64'(last_ok), 64'd0);
        eng_hang = 0;

        // Done on the same cycle the timeout would fire
        eng_d = TO;
        r0 = rsp_cnt;
        issue(3, 64'd5, 64'd94, 64'd57, 64'd42, acc);
        wait_rsp(r0);
        chk("t5_latency", 64'(rsp_cyc - acc), 64'd66);
        chk("t5_err", 64'(last_err), 64'd0);
        chk("t5_ok", 64'(last_ok), 64'd1);

        // r == q
        eng_d = 10;
        r0 = rsp_cnt; s0 = start_cnt;
        issue(0, 64'd9, 64'd101, 64'd5, 64'd1, acc);
        wait_rsp(r0);
`ifdef DSA_SCHED_RANGE_CHECK_EN
        chk("t6_latency", 64'(rsp_cyc - acc), 64'd1);
        chk("t6_err", 64'(last_err), 64'd1);
        chk("t6_starts", 64'(start_cnt - s0), 64'd0);
`else
        chk("t6_latency", 64'(rsp_cyc - acc), 64'd12);
        chk("t6_err", 64'(last_err), 64'd0);
        chk("t6_starts", 64'(start_cnt - s0), 64'd1);
`endif

        // Reset pulse during WAIT
        r0 = rsp_cnt;
        issue(1, 64'd21, 64'd94, 64'd57, 64'd42, acc);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t7_idle", 64'(cfg_busy), 64'd0);
        chk("t7_cfg_cleared", eng_q, 64'd0);
        repeat (20) @(negedge clk);
        chk("t7_no_rsp", 64'(rsp_cnt), 64'(r0));
        cfg_wr(3'd1, 64'd101);
        r0 = rsp_cnt;
        issue(0, 64'd23, 64'd94, 64'd57, 64'd42, acc);
        wait_rsp(r0);
        chk("t7_after_latency", 64'(rsp_cyc - acc), 64'd12);
        chk("t7_after_owner", 64'(rlog[rlog.size()-1]), 64'b0001);

        // Random traffic
        eng_d = $urandom_range(2, 8);
        for (int c = 0; c < 600; c++) begin
            logic [NR-1:0] accd;
            @(negedge clk);
            accd = req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin
                if (accd[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        ry  = {$urandom, $urandom};
                        rr_ = 64'($urandom_range(0, 120));
                        rs  = 64'($urandom_range(0, 120));
                        set_req(i, ry, rr_, rs, {$urandom, $urandom});
                        req_valid[i] = 1'b1;
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            cfg_we = ($urandom_range(0, 7) == 0);
            a_rnd = $urandom_range(0, 6);
            cfg_addr  = (a_rnd == 1) ? 3'd7 : 3'(a_rnd);
            cfg_wdata = {$urandom, $urandom};
        end
        @(posedge clk); #1;
        req_valid = '0;
        cfg_we = 1'b0;
        for (int t = 0; t < 300 && cfg_busy; t++) @(negedge clk);
        @(negedge clk);
        chk("final_idle", 64'(cfg_busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dsa_check_sched.md
# dsa_check_sched

Scheduler and configuration front-end for one shared `dsa_check` engine. It holds the DSA domain parameters and Montgomery constants in software-written registers. It arbitrates round-robin among `N_REQ` signature-verify requesters, launches the engine once per accepted request, and returns a per-requester verdict with timeout and optional range rejection. It sits between the requesting clients and the single `dsa_check` instance.

## Interface
Parameters:
- `LEN`, 64, operand width; must match the engine's `LEN`.
- `N_REQ`, 4, number of requesters (2..16).
- `TIMEOUT`, 4096, maximum WAIT cycles before an error response.

Ports:
- `clk`  in  1  clock (one clock).
- `rst_n`  in  1  reset, synchronous, active-low.
- `cfg_we`  in  1  config write strobe.
- `cfg_addr`  in  3  0=p, 1=q, 2=g, 3=p_prime, 4=r2_mod_p, 5=q_prime, 6=r2_mod_q, 7=ignored.
- `cfg_wdata`  in  LEN  config write data.
- `cfg_busy`  out  1  high whenever state is not IDLE.
- `req_valid`  in  N_REQ  per-requester request.
- `req_ready`  out  N_REQ  one-hot accept.
- `req_y`, `req_r`, `req_s`, `req_z`  in  N_REQ*LEN each  flattened operands; slice i belongs to requester i.
- `rsp_valid`  out  N_REQ  one-cycle, one-hot response pulse.
- `rsp_ok`  out  1  verdict, qualified by `rsp_valid`.
- `rsp_err`  out  1  timeout or range reject, qualified by `rsp_valid`.
- `eng_start`  out  1  engine start pulse.
- `eng_p`, `eng_q`, `eng_g`, `eng_p_prime`, `eng_r2_mod_p`, `eng_q_prime`, `eng_r2_mod_q`  out  LEN  config register outputs.
- `eng_y`, `eng_r`, `eng_s`, `eng_z`  out  LEN  latched operands.
- `eng_valid`, `eng_done`  in  1  engine result and completion.

## Operation
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If `cfg_we`=1, write the addressed register. No grant is issued that cycle.
  - Otherwise, if any `req_valid` is set, grant the first set bit searching from `last+1` modulo `N_REQ`. Assert `req_ready[i]` combinationally and latch slice i of y/r/s/z.
  - Record `last`=i and `owner`=i, then go to LAUNCH.
- Config writes outside IDLE are ignored. `cfg_addr`=7 writes nothing.
- LAUNCH: `eng_start`=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - The first WAIT cycle masks `eng_done`, because the engine clears it only after sampling start.
  - From the second WAIT cycle on, `eng_done`=1 captures `eng_valid` into `rsp_ok`, sets `rsp_err`=0, and goes to RESP.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT`, set `rsp_ok`=0 and `rsp_err`=1, then go to RESP.
  - If `eng_done` and timeout occur in the same cycle, `eng_done` wins.
- RESP: `rsp_valid[owner]`=1 for one cycle; go to IDLE.
- The engine operand outputs hold the latched values until the next grant.
- The requester keeps `req_valid` asserted until `req_ready`. After acceptance it may drop `req_valid` or present a new request.

## Timing
- Reset values:
  - state IDLE.
  - All config registers 0.
  - `last`=N_REQ-1, so requester 0 wins first.
  - `eng_start`, `req_ready`, `rsp_valid`, `rsp_ok`, `rsp_err`, `cfg_busy` all 0.
  - Operand latches 0.
- Latency with the engine completing at WAIT cycle k (k≥2): accept at cycle 0, `eng_start` at 1, `rsp_valid` at 2+k. The next accept is possible at 3+k.
- Range-reject path: accept at 0, `rsp_valid` at 1, no `eng_start`.
- `rst_n` low mid-operation: return to IDLE the next edge, drop `eng_start`, and emit no response. The engine has no reset; its next `eng_start` restarts it.
- Timeout counter is `$clog2(TIMEOUT+1)` bits wide and saturates at `TIMEOUT`.

## Configuration
- `DSA_SCHED_RANGE_CHECK_EN` defined: at accept, if r==0, r≥q, s==0 or s≥q (unsigned LEN-bit compares against the config q), skip LAUNCH/WAIT. Go directly to RESP with `rsp_ok`=0 and `rsp_err`=1.
- Undefined: every accepted request is launched to the engine unchecked.

## Structure
- Package `dsa_sched_pkg`:
  - state enum `sched_state_t`.
  - `CFG_P`..`CFG_R2Q` address constants.
- Sub-module `dsa_rr_arbiter` (params `N`):
  - inputs: `req`, `last`, `en`.
  - outputs: one-hot `gnt`, index `gnt_idx`.
  - purely combinational.

## Test plan
The bench uses a behavioural engine model with configurable done delay D and result V.
- Reset, then write config p=7879, q=101, g=170, p_prime=64'h256e1d0c1e8abd09, r2_mod_p=64'hd48, q_prime=64'hc5b3f5dc83cd4e93, r2_mod_q=64'h50. Then requester 0 sends y=4567, r=94, s=57, z=42 with D=10, V=1. Required: `eng_*` ports match these values, one `eng_start` pulse, `rsp_valid`=4'b0001 with `rsp_ok`=1 exactly 12 cycles after accept.
- Requesters 0..3 all held valid, D=3. Required: grants in order 0,1,2,3,0; each response goes to its owner; `rsp_ok` follows V toggled per op.
- Write attempt during WAIT to q=7. Required: ignored; `cfg_busy`=1; `eng_q` stays 101.
- Engine never asserts done, TIMEOUT=64. Required: response at accept+66 with `rsp_err`=1, `rsp_ok`=0.
- With the macro defined, r=101 (=q). Required: response one cycle after accept, `rsp_err`=1, no `eng_start`. Without the macro, the same request launches normally.
- `rst_n` low for one cycle during WAIT. Required: IDLE next cycle, no `rsp_valid`; the following request completes normally.
